// File: rtl/rca_seq_pkg.sv
// Shared types and helpers for the multi-word ripple-carry sequencer.
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word-index width: ceil(log2(n_words)), never narrower than one bit.
    function automatic int idx_width(input int n_words);
        int w;
        if (n_words <= 1) begin
            w = 1;
        end else begin
            w = $clog2(n_words);
        end
        return w;
    endfunction

endpackage

// File: rtl/rca_word_slice.sv
// One W-bit ripple-carry adder slice, purely combinational.
// c_msb is the carry into bit W-1, used for two's-complement overflow.
import rca_seq_pkg::*;

module rca_word_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [W:0] full_s;

    // W-bit sum with one extra bit to capture the carry-out.
    always_comb begin
        full_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

    assign s     = full_s[W-1:0];
    assign cout  = full_s[W];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out by XOR.
    assign c_msb = full_s[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/rca_multiword_sequencer.sv
// Multi-word adder sequencer: accepts an N_WORDS*W operand pair, adds it one
// W-bit word per cycle (LS word first) through a single slice with a
// registered carry, and hands the full sum downstream over valid/ready.
// Optional feature macro: OVF_DETECT_EN (adds OVF_o, signed overflow flag).
import rca_seq_pkg::*;

module rca_multiword_sequencer #(
    parameter int W       = 8,
    parameter int N_WORDS = 4
) (
    input  logic                 CLK_i,
    input  logic                 RST_I,
    input  logic                 IN_VALID_i,
    output logic                 IN_READY_o,
    input  logic [N_WORDS*W-1:0] A_i,
    input  logic [N_WORDS*W-1:0] B_i,
    input  logic                 CIN_i,
    output logic                 OUT_VALID_o,
    input  logic                 OUT_READY_i,
    output logic [N_WORDS*W-1:0] SUM_o,
    output logic                 COUT_o,
    output logic                 BUSY_o
`ifdef OVF_DETECT_EN
    ,
    output logic                 OVF_o
`endif
);

    localparam int DW = N_WORDS * W;
    localparam int IW = idx_width(N_WORDS);

    state_t          state_r;
    logic [IW-1:0]   idx_r;
    logic            carry_r;
    logic [DW-1:0]   a_r;
    logic [DW-1:0]   b_r;
    logic [DW-1:0]   sum_r;
    logic            cout_r;
    logic            out_valid_r;
    logic            busy_r;

    logic [DW-1:0]   a_shift_s;
    logic [DW-1:0]   b_shift_s;
    logic [W-1:0]    a_word_s;
    logic [W-1:0]    b_word_s;
    logic [W-1:0]    slice_sum_s;
    logic            slice_cout_s;
    logic            slice_c_msb_s;
    logic            last_word_s;

    // Select the current operand words by shifting the captured operands down.
    always_comb begin
        a_shift_s   = a_r >> (int'(idx_r) * W);
        b_shift_s   = b_r >> (int'(idx_r) * W);
        a_word_s    = a_shift_s[W-1:0];
        b_word_s    = b_shift_s[W-1:0];
        last_word_s = (idx_r == IW'(N_WORDS - 1));
    end

    rca_word_slice #(
        .W (W)
    ) u_slice (
        .a     (a_word_s),
        .b     (b_word_s),
        .cin   (carry_r),
        .s     (slice_sum_s),
        .cout  (slice_cout_s),
        .c_msb (slice_c_msb_s)
    );

`ifdef OVF_DETECT_EN
    logic ovf_r;

    // Overflow flag latched alongside the final carry-out; cleared on reset/accept.
    always_ff @(posedge CLK_i) begin
        if (RST_I) begin
            ovf_r <= 1'b0;
        end else if ((state_r == IDLE) && IN_VALID_i) begin
            ovf_r <= 1'b0;
        end else if ((state_r == RUN) && last_word_s) begin
            ovf_r <= slice_c_msb_s ^ slice_cout_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign OVF_o = ovf_r;
`else
    logic unused_c_msb_s;
    assign unused_c_msb_s = slice_c_msb_s;
`endif

    // Control FSM and datapath registers; reset overrides everything.
    always_ff @(posedge CLK_i) begin
        if (RST_I) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (IN_VALID_i) begin
                        a_r     <= A_i;
                        b_r     <= B_i;
                        carry_r <= CIN_i;
                        idx_r   <= '0;
                        sum_r   <= '0;
                        cout_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N_WORDS; i++) begin
                        if (idx_r == IW'(i)) begin
                            sum_r[i*W +: W] <= slice_sum_s;
                        end
                    end
                    carry_r <= slice_cout_s;
                    if (last_word_s) begin
                        cout_r      <= slice_cout_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                DONE: begin
                    if (OUT_READY_i) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        idx_r       <= '0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    idx_r       <= '0;
                    carry_r     <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY_o  = (state_r == IDLE) && !RST_I;
    assign OUT_VALID_o = out_valid_r;
    assign SUM_o       = sum_r;
    assign COUT_o      = cout_r;
    assign BUSY_o      = busy_r;

endmodule
